// File: rtl/perceptron_pt_pkg.sv
// perceptron_pkg: shared parameters and weight types for the perceptron
// predictor and its trainer.
//   BHR_W     global history length; a row holds BHR_W+1 weights (index BHR_W = bias)
//   WEIGHT_W  signed weight / y_out width
//   PT_IDX_W  table index width, taken from PC[PT_IDX_W-1:0]
//   PT_W      row count
//   ACC_W     dot-product accumulator width
//   sat_weight()  clamps an accumulator value into the weight range
package perceptron_pkg;
  localparam int BHR_W    = 8;
  localparam int WEIGHT_W = 8;
  localparam int PT_IDX_W = 6;
  localparam int PT_W     = 1 << PT_IDX_W;
  // Worst case is (BHR_W+1) * 2^(WEIGHT_W-1) in magnitude, which fits with this headroom.
  localparam int ACC_W    = WEIGHT_W + $clog2(BHR_W + 2);

  typedef logic signed [WEIGHT_W-1:0] weight_t;
  typedef weight_t [BHR_W:0]          weight_row_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((1 << (WEIGHT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;

  function automatic weight_t sat_weight(input logic signed [ACC_W-1:0] acc);
    weight_t y;
    if (acc > ACC_MAX)      y = {1'b0, {(WEIGHT_W-1){1'b1}}};
    else if (acc < ACC_MIN) y = {1'b1, {(WEIGHT_W-1){1'b0}}};
    else                    y = acc[WEIGHT_W-1:0];
    return y;
  endfunction
endpackage

// File: rtl/perceptron_pt_if.sv
// perceptron_pt_if: fetch-lookup, recovery and trainer signals of the
// perceptron table. Signal names are as seen from the table (_i = into the
// table, _o = out of it).
//   master : fetch / ROB / trainer side (drives lookups, flush, recovery, writes)
//   slave  : perceptron table side (serves predictions and trainer reads)
interface perceptron_pt_if;
  import perceptron_pkg::*;

  logic                if_br_vld_i;
  logic [63:0]         if_br_PC_i;
  logic                flush_i;
  logic                rec_en_i;
  logic [BHR_W-1:0]    rec_BHR_i;
  logic [63:0]         fu_br_PC_i;
  logic                tr2pt_wr_en_i;
  logic [PT_IDX_W-1:0] tr2pt_wr_idx_i;
  weight_row_t         new_weight_i;
  weight_row_t         sel_weight_o;
  logic                y_vld_o;
  weight_t             y_out_o;
  logic                pred_taken_o;
  logic [BHR_W-1:0]    bhr_snap_o;
  logic [BHR_W-1:0]    BHR_o;

  modport master (
    output if_br_vld_i, if_br_PC_i, flush_i, rec_en_i, rec_BHR_i, fu_br_PC_i,
           tr2pt_wr_en_i, tr2pt_wr_idx_i, new_weight_i,
    input  sel_weight_o, y_vld_o, y_out_o, pred_taken_o, bhr_snap_o, BHR_o
  );

  modport slave (
    input  if_br_vld_i, if_br_PC_i, flush_i, rec_en_i, rec_BHR_i, fu_br_PC_i,
           tr2pt_wr_en_i, tr2pt_wr_idx_i, new_weight_i,
    output sel_weight_o, y_vld_o, y_out_o, pred_taken_o, bhr_snap_o, BHR_o
  );
endinterface

// File: rtl/perceptron_dot.sv
// perceptron_dot: combinational perceptron output.
//   y = w[BHR_W] + sum_i (bhr[i] ? +w[i] : -w[i]), saturated to WEIGHT_W bits.
// Ports:
//   i_row  weight row (index BHR_W = bias)
//   i_bhr  global history
//   o_y    saturated signed result
module perceptron_dot
  import perceptron_pkg::*;
(
  input  weight_row_t      i_row,
  input  logic [BHR_W-1:0] i_bhr,
  output weight_t          o_y
);
  logic signed [ACC_W-1:0] w_term [BHR_W+1];
  logic signed [ACC_W-1:0] w_acc;

  for (genvar i = 0; i < BHR_W; i++) begin : g_term
    logic signed [ACC_W-1:0] w_ext;
    assign w_ext     = {{(ACC_W-WEIGHT_W){i_row[i][WEIGHT_W-1]}}, i_row[i]};
    // Negating the most negative weight is safe: the accumulator has headroom.
    assign w_term[i] = i_bhr[i] ? w_ext : -w_ext;
  end

  assign w_term[BHR_W] = {{(ACC_W-WEIGHT_W){i_row[BHR_W][WEIGHT_W-1]}}, i_row[BHR_W]};

  always_comb begin
    w_acc = '0;
    for (int k = 0; k <= BHR_W; k++) w_acc = w_acc + w_term[k];
  end

  assign o_y = sat_weight(w_acc);
endmodule

// File: rtl/perceptron_pt.sv
// perceptron_pt: perceptron weight table and predictor.
//   - PT_W rows of BHR_W+1 signed weights, written whole by the trainer.
//   - 2-stage lookup: stage 1 latches row + BHR, stage 2 registers the
//     saturated dot product; y_vld_o two cycles after if_br_vld_i.
//   - Owns the speculative BHR (shifted by each prediction, restored on recovery).
// Ports:
//   clk, rst  clock; asynchronous active-high reset
//   bus       perceptron_pt_if.slave: lookup request, flush, recovery,
//             trainer read/write, prediction outputs, BHR
module perceptron_pt
  import perceptron_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  perceptron_pt_if.slave bus
);
  localparam int STAGES = 2;

  weight_row_t         r_table [PT_W];
  logic [STAGES:1]     r_vld;
  weight_row_t         r_s1_row;
  logic [BHR_W-1:0]    r_s1_bhr;
  weight_t             r_y;
  logic [BHR_W-1:0]    r_snap;
  logic [BHR_W-1:0]    r_bhr;

  logic                w_kill;
  logic                w_lkp;
  logic [STAGES:0]     vld_pipe;
  logic [PT_IDX_W-1:0] w_idx;
  weight_row_t         w_row;
  weight_t             w_y;
  logic                w_unused;

  // Recovery squashes the pipeline exactly like a flush, including a lookup
  // presented in the same cycle.
  assign w_kill   = bus.flush_i | bus.rec_en_i;
  assign w_lkp    = bus.if_br_vld_i & ~w_kill;
  assign vld_pipe = {r_vld, w_lkp};

  assign w_idx = bus.if_br_PC_i[PT_IDX_W-1:0];

  // Lookup-side bypass so a same-cycle trainer write is not missed by stage 1.
  always_comb begin
    w_row = r_table[w_idx];
    if (bus.tr2pt_wr_en_i && (bus.tr2pt_wr_idx_i == w_idx)) w_row = bus.new_weight_i;
  end

  // Weight table. The trainer read is deliberately taken from the stored
  // array only; a bypass there would close a loop through the trainer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < PT_W; r++) r_table[r] <= '0;
    end else if (bus.tr2pt_wr_en_i) begin
      r_table[bus.tr2pt_wr_idx_i] <= bus.new_weight_i;
    end
  end

  assign bus.sel_weight_o = r_table[bus.fu_br_PC_i[PT_IDX_W-1:0]];

  perceptron_dot u_dot (
    .i_row (r_s1_row),
    .i_bhr (r_s1_bhr),
    .o_y   (w_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld    <= '0;
      r_s1_row <= '0;
      r_s1_bhr <= '0;
      r_y      <= '0;
      r_snap   <= '0;
      r_bhr    <= '0;
    end else begin
      r_vld <= vld_pipe[STAGES-1:0] & {STAGES{~w_kill}};
      if (vld_pipe[0]) begin
        r_s1_row <= w_row;
        r_s1_bhr <= r_bhr;
      end
      // Result/snapshot only move with a surviving lookup so they hold while idle.
      if (vld_pipe[1] && !w_kill) begin
        r_y    <= w_y;
        r_snap <= r_s1_bhr;
      end
      if (bus.rec_en_i)            r_bhr <= bus.rec_BHR_i;
      else if (vld_pipe[STAGES])   r_bhr <= {r_bhr[BHR_W-2:0], ~r_y[WEIGHT_W-1]};
    end
  end

  assign bus.y_vld_o      = r_vld[STAGES];
  assign bus.y_out_o      = r_y;
  assign bus.pred_taken_o = ~r_y[WEIGHT_W-1];
  assign bus.bhr_snap_o   = r_snap;
  assign bus.BHR_o        = r_bhr;

  // Only the low PC bits index the table.
  assign w_unused = ^{bus.if_br_PC_i[63:PT_IDX_W], bus.fu_br_PC_i[63:PT_IDX_W]};
endmodule
